// File: rtl/instr_mem_fetch_if.sv
// Fetch request/response handshake bundle between a fetch unit and instr_mem_fetch.
interface instr_mem_fetch_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic              rsp_fault;

    modport master (
        output req_valid, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault
    );

    modport slave (
        input  req_valid, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_fault
    );
endinterface

// File: rtl/instr_mem_fetch.sv
// Loadable instruction memory with a 1-cycle-latency valid/ready fetch port.
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module instr_mem_fetch #(
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          DEPTH     = 16,
    parameter logic [31:0]          BASE_ADDR = 32'h0,
    parameter logic [DATA_W-1:0]    NOP_WORD  = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_mode,
    input  logic                       load_valid,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic [DATA_W-1:0]          load_data,
    instr_mem_fetch_if.slave           bus,
    output logic [$clog2(DEPTH):0]     load_count,
    output logic                       parity_err
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_LOAD  = 2'd1;
    localparam logic [1:0]  S_RUN   = 2'd2;
    localparam logic [32:0] SPAN    = 33'(DEPTH) << 2;
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_instr;
    logic              r_rsp_fault;
    logic [AW:0]       r_load_count;
    logic              r_parity_err;

    logic              w_rsp_hs;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_load_we;
    logic              w_enter_load;
    logic [31:0]       w_off;
    logic              w_in_range;
    logic [AW-1:0]     w_idx;
    logic [DATA_W-1:0] w_word;
    logic              w_par_bad;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and handshake qualifiers
    always_comb begin
        w_state_nxt  = r_state;
        w_rsp_hs     = r_rsp_valid & bus.rsp_ready;
        w_req_ready  = (r_state == S_RUN) && (!r_rsp_valid || bus.rsp_ready);
        w_accept     = bus.req_valid & w_req_ready;
        w_load_we    = (r_state == S_LOAD) & load_valid;
        case (r_state)
            S_IDLE:  w_state_nxt = load_mode ? S_LOAD : S_RUN;
            S_LOAD:  if (!load_mode) w_state_nxt = S_RUN;
            S_RUN:   if (load_mode && (!r_rsp_valid || w_rsp_hs)) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
        w_enter_load = (w_state_nxt == S_LOAD) && (r_state != S_LOAD);
    end

    // Offset is taken modulo 2^32, so anything below BASE_ADDR wraps far above SPAN
    always_comb begin
        w_off      = bus.req_pc - BASE_ADDR;
        w_in_range = ({1'b0, w_off} < SPAN) && (bus.req_pc[1:0] == 2'b00);
        w_idx      = w_off[AW+1:2];
        w_word     = r_mem[w_idx];
    end

    // Storage is deliberately not reset so a program survives rst_n
    always_ff @(posedge clk) begin
        if (w_load_we) r_mem[load_addr] <= load_data;
    end

`ifdef IMEM_PARITY_EN
    logic r_par [DEPTH];

    always_ff @(posedge clk) begin
        if (w_load_we) r_par[load_addr] <= ^load_data;
    end

    assign w_par_bad = w_in_range && ((^w_word) != r_par[w_idx]);
`else
    assign w_par_bad = 1'b0;
`endif

    // Response register: holds under backpressure, reloads on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= NOP_WORD;
            r_rsp_fault <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            if (w_in_range && !w_par_bad) begin
                r_rsp_instr <= w_word;
                r_rsp_fault <= 1'b0;
            end else begin
                r_rsp_instr <= NOP_WORD;
                r_rsp_fault <= 1'b1;
            end
        end else if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Write counter and sticky parity flag, both restarted on LOAD entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_count <= '0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_enter_load) begin
                r_load_count <= '0;
            end else if (w_load_we && (r_load_count != CNT_MAX)) begin
                r_load_count <= r_load_count + (AW+1)'(1);
            end
            if (w_enter_load) begin
                r_parity_err <= 1'b0;
            end else if (w_accept && w_par_bad) begin
                r_parity_err <= 1'b1;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_instr = r_rsp_instr;
    assign bus.rsp_fault = r_rsp_fault;
    assign load_count    = r_load_count;
    assign parity_err    = r_parity_err;
endmodule

// File: tb/tb_instr_mem_fetch.sv
// Randomised self-checking bench for instr_mem_fetch (low-base and high-base instances).
module tb_instr_mem_fetch;
    localparam int unsigned DW      = 32;
    localparam int unsigned DEPTH   = 16;
    localparam logic [31:0] HI_BASE = 32'hFFFF_FFC0;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_mode, load_valid;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic [4:0]  cnt_a, cnt_b;
    logic        perr_a, perr_b;

    instr_mem_fetch_if #(.DATA_W(DW)) bus_a ();
    instr_mem_fetch_if #(.DATA_W(DW)) bus_b ();

    always #5 clk = ~clk;

    instr_mem_fetch #(.DATA_W(DW), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .NOP_WORD(32'h0)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .load_valid(load_valid),
        .load_addr(load_addr), .load_data(load_data), .bus(bus_a),
        .load_count(cnt_a), .parity_err(perr_a));

    instr_mem_fetch #(.DATA_W(DW), .DEPTH(DEPTH), .BASE_ADDR(HI_BASE), .NOP_WORD(32'h0)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .load_valid(load_valid),
        .load_addr(load_addr), .load_data(load_data), .bus(bus_b),
        .load_count(cnt_b), .parity_err(perr_b));

    // Stimulus for the next cycle
    logic        d_rst, d_mode, d_lv, d_v, d_rr, d_bv;
    logic [3:0]  d_la;
    logic [31:0] d_ld, d_pc, d_bpc;

    // Reference model, one copy per instance
    logic [31:0] m_mem  [2][DEPTH];
    bit          m_bad  [2][DEPTH];
    bit          m_idle [2];
    bit          m_load [2];
    bit          m_run  [2];
    int          m_cnt  [2];
    bit          m_perr [2];
    bit          m_pend [2];
    rsp_t        m_head [2];

    // {req_ready, rsp_valid, instr, fault, load_count, parity_err}
    logic [40:0] obs  [2];
    logic [40:0] expv [2];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic rsp_t ref_fetch(input int k, input logic [31:0] pc, output bit bad);
        longint unsigned p, b, w;
        rsp_t r;
        p = {32'h0, pc};
        b = {32'h0, (k == 1) ? HI_BASE : 32'h0};
        r.instr = 32'h0;
        r.fault = 1'b1;
        bad = 1'b0;
        if (p >= b && p < b + 4 * DEPTH && (p % 4) == 0) begin
            w = (p - b) / 4;
            if (m_bad[k][int'(w)]) bad = 1'b1;
            else begin
                r.instr = m_mem[k][int'(w)];
                r.fault = 1'b0;
            end
        end
        return r;
    endfunction

    // Drive one cycle, capture outputs mid-cycle, advance the model across the edge
    task automatic cycle();
        bit ev, er, v, rr, bad;
        logic [31:0] pc;
        rsp_t hd;
        @(negedge clk);
        rst_n = d_rst; load_mode = d_mode; load_valid = d_lv; load_addr = d_la; load_data = d_ld;
        bus_a.req_valid = d_v;  bus_a.req_pc = d_pc;  bus_a.rsp_ready = d_rr;
        bus_b.req_valid = d_bv; bus_b.req_pc = d_bpc; bus_b.rsp_ready = 1'b1;
        #1;
        obs[0] = {bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_valid ? bus_a.rsp_instr : 32'h0,
                  bus_a.rsp_valid & bus_a.rsp_fault, cnt_a, perr_a};
        obs[1] = {bus_b.req_ready, bus_b.rsp_valid, bus_b.rsp_valid ? bus_b.rsp_instr : 32'h0,
                  bus_b.rsp_valid & bus_b.rsp_fault, cnt_b, perr_b};
        for (int k = 0; k < 2; k++) begin
            v  = (k == 0) ? d_v  : d_bv;
            pc = (k == 0) ? d_pc : d_bpc;
            rr = (k == 0) ? d_rr : 1'b1;
            if (!d_rst) begin
                m_idle[k] = 1; m_run[k] = 0; m_load[k] = 0;
                m_cnt[k] = 0; m_perr[k] = 0; m_pend[k] = 0;
            end
            ev = m_pend[k];
            er = m_run[k] && (!ev || rr);
            hd = ev ? m_head[k] : '0;
            expv[k] = {er, ev, hd.instr, hd.fault, 5'(m_cnt[k]), m_perr[k]};
            if (d_rst) begin
                if (ev && rr) m_pend[k] = 0;
                if (v && er) begin
                    m_head[k] = ref_fetch(k, pc, bad);
                    m_pend[k] = 1;
                    if (bad) m_perr[k] = 1;
                end
                if (m_load[k] && d_lv) begin
                    m_mem[k][d_la] = d_ld;
                    m_bad[k][d_la] = 0;
                    if (m_cnt[k] < DEPTH) m_cnt[k]++;
                end
                if (m_idle[k]) begin
                    m_idle[k] = 0; m_load[k] = d_mode; m_run[k] = !d_mode;
                end else if (m_run[k] && d_mode && (!ev || rr)) begin
                    m_run[k] = 0; m_load[k] = 1; m_cnt[k] = 0; m_perr[k] = 0;
                end else if (m_load[k] && !d_mode) begin
                    m_load[k] = 0; m_run[k] = 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        d_rst = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== expv[k]) begin
                    n_fail++;
                    $display("FAIL reset dut%0d cyc%0d: got %h want %h", k, i, obs[k], expv[k]);
                end
            end
        end
        n_tests++;
        if (bus_a.rsp_instr !== 32'h0 || bus_b.rsp_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_instr: got %h/%h want 0", bus_a.rsp_instr, bus_b.rsp_instr);
        end
        d_rst = 1; d_mode = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== expv[k]) begin
                    n_fail++;
                    $display("FAIL idle_exit dut%0d cyc%0d: got %h want %h", k, i, obs[k], expv[k]);
                end
            end
        end
    endtask

    task automatic test_load_fetch();
        logic [31:0] prog [4];
        prog[0] = 32'h00041800; prog[1] = 32'h00051800;
        prog[2] = 32'h00061800; prog[3] = 32'h00071800;
        // Fill all words, then one extra write to exercise count saturation
        for (int i = 0; i < 24; i++) begin
            d_mode = (i < 20 || i > 21);
            d_lv   = (i >= 1 && i <= 17);
            d_la   = 4'(i - 1);
            d_ld   = $urandom;
            if (i >= 22 && i <= 23) d_lv = 0;
            if (i == 23) d_mode = 1;
            if (i >= 24) d_lv = 0;
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== expv[k]) begin
                    n_fail++;
                    $display("FAIL load_fill dut%0d cyc%0d: got %h want %h", k, i, obs[k], expv[k]);
                end
            end
        end
        // Fresh LOAD session: four program words
        for (int i = 0; i < 6; i++) begin
            d_mode = (i < 5);
            d_lv   = (i < 4);
            d_la   = 4'(i);
            d_ld   = (i < 4) ? prog[i] : 32'h0;
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== expv[k]) begin
                    n_fail++;
                    $display("FAIL load_prog dut%0d cyc%0d: got %h want %h", k, i, obs[k], expv[k]);
                end
            end
        end
        // Fetch pc 0..12 while a stray write strobe is held in RUN
        d_lv = 1; d_la = 4'd1; d_ld = 32'hDEAD_BEEF; d_rr = 1;
        for (int i = 0; i < 6; i++) begin
            d_v  = (i < 4);
            d_pc = 32'(i * 4);
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== expv[k]) begin
                    n_fail++;
                    $display("FAIL fetch dut%0d cyc%0d: got %h want %h", k, i, obs[k], expv[k]);
                end
            end
            if (i >= 1 && i <= 4) begin
                n_tests++;
                if (obs[0][39:6] !== {1'b1, prog[i-1], 1'b0} || obs[0][5:1] !== 5'd4) begin
                    n_fail++;
                    $display("FAIL prog_word%0d: got %h want %h cnt 4", i - 1, obs[0][39:1], prog[i-1]);
                end
            end
        end
        d_lv = 0;
    endtask

    task automatic test_fault();
        logic [31:0] pcs [7];
        pcs[0] = 32'd64; pcs[1] = 32'd6; pcs[2] = 32'hFFFF_FFFC; pcs[3] = 32'd62;
        pcs[4] = 32'd60; pcs[5] = 32'd2; pcs[6] = 32'd0;
        d_rr = 1;
        for (int i = 0; i < 9; i++) begin
            d_v  = (i < 7);
            d_pc = pcs[(i < 7) ? i : 6];
            cycle();
            n_tests++;
            if (obs[0] !== expv[0]) begin
                n_fail++;
                $display("FAIL fault cyc%0d: got %h want %h", i, obs[0], expv[0]);
            end
        end
        d_v = 0;
    endtask

    task automatic test_high_base();
        logic [31:0] pcs [7];
        pcs[0] = 32'h0;          pcs[1] = HI_BASE;        pcs[2] = HI_BASE + 32'd4;
        pcs[3] = HI_BASE + 32'd60; pcs[4] = HI_BASE - 32'd4; pcs[5] = HI_BASE + 32'd2;
        pcs[6] = 32'h3C;
        for (int i = 0; i < 9; i++) begin
            d_bv  = (i < 7);
            d_bpc = pcs[(i < 7) ? i : 6];
            cycle();
            n_tests++;
            if (obs[1] !== expv[1]) begin
                n_fail++;
                $display("FAIL high_base cyc%0d: got %h want %h", i, obs[1], expv[1]);
            end
        end
        d_bv = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] pcs [6];
        int idx = 0;
        int n_resp = 0;
        for (int j = 0; j < 6; j++) pcs[j] = 32'(j * 4 + 16);
        for (int i = 0; i < 12; i++) begin
            d_v  = (idx < 6);
            d_pc = pcs[(idx < 6) ? idx : 5];
            d_rr = !(i >= 1 && i <= 3);
            cycle();
            n_tests++;
            if (obs[0] !== expv[0]) begin
                n_fail++;
                $display("FAIL backpressure cyc%0d: got %h want %h", i, obs[0], expv[0]);
            end
            if (obs[0][39] && d_rr) n_resp++;
            if (d_v && expv[0][40]) idx++;
        end
        n_tests++;
        if (n_resp != 6) begin
            n_fail++;
            $display("FAIL backpressure_count: got %0d responses want 6", n_resp);
        end
        d_v = 0; d_rr = 1;
    endtask

    task automatic test_reset_mid();
        d_v = 1; d_pc = 32'd12; d_rr = 0;
        cycle();
        d_v = 0;
        cycle();
        n_tests++;
        if (obs[0] !== expv[0]) begin
            n_fail++;
            $display("FAIL rst_mid_pending: got %h want %h", obs[0], expv[0]);
        end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if (bus_a.rsp_valid !== 1'b0 || bus_a.req_ready !== 1'b0 || bus_a.rsp_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got v%b r%b i%h want v0 r0 i0",
                     bus_a.rsp_valid, bus_a.req_ready, bus_a.rsp_instr);
        end
        d_rst = 0;
        cycle();
        d_rst = 1; d_mode = 0; d_rr = 1;
        for (int i = 0; i < 5; i++) begin
            d_v  = (i == 2);
            d_pc = 32'd4;
            cycle();
            n_tests++;
            if (obs[0] !== expv[0]) begin
                n_fail++;
                $display("FAIL rst_mid_after cyc%0d: got %h want %h", i, obs[0], expv[0]);
            end
            if (i == 3) begin
                n_tests++;
                if (obs[0][39:6] !== {1'b1, 32'h00051800, 1'b0}) begin
                    n_fail++;
                    $display("FAIL rst_retain: got %h want 00051800", obs[0][38:7]);
                end
            end
        end
        d_v = 0;
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        cycle();
        dut_a.r_par[2] = ~dut_a.r_par[2];
        m_bad[0][2] = 1;
        for (int i = 0; i < 8; i++) begin
            d_v   = (i == 0);
            d_pc  = 32'd8;
            d_rst = !(i == 4);
            cycle();
            n_tests++;
            if (obs[0] !== expv[0]) begin
                n_fail++;
                $display("FAIL parity cyc%0d: got %h want %h", i, obs[0], expv[0]);
            end
            if (i == 3) begin
                n_tests++;
                if (perr_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL parity_sticky: got %b want 1", perr_a);
                end
            end
        end
        d_v = 0; d_rst = 1;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) d_mode = !d_mode;
            d_lv  = $urandom_range(0, 1);
            d_la  = 4'($urandom_range(0, 15));
            d_ld  = $urandom;
            d_v   = ($urandom_range(0, 3) != 0);
            d_bv  = ($urandom_range(0, 3) != 0);
            d_rr  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0, 1: begin d_pc = 32'($urandom_range(0, 15) * 4);
                            d_bpc = HI_BASE + 32'($urandom_range(0, 15) * 4); end
                2:    begin d_pc = 32'($urandom_range(0, 70));
                            d_bpc = HI_BASE + 32'($urandom_range(0, 70)) - 32'd4; end
                default: begin d_pc = $urandom; d_bpc = $urandom; end
            endcase
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== expv[k]) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d: got %h want %h", k, i, obs[k], expv[k]);
                end
            end
        end
        d_mode = 0; d_lv = 0; d_v = 0; d_bv = 0; d_rr = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== expv[k]) begin
                    n_fail++;
                    $display("FAIL drain dut%0d cyc%0d: got %h want %h", k, i, obs[k], expv[k]);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; load_mode = 0; load_valid = 0; load_addr = '0; load_data = '0;
        bus_a.req_valid = 0; bus_a.req_pc = '0; bus_a.rsp_ready = 1;
        bus_b.req_valid = 0; bus_b.req_pc = '0; bus_b.rsp_ready = 1;
        d_rst = 0; d_mode = 0; d_lv = 0; d_la = '0; d_ld = '0;
        d_v = 0; d_pc = '0; d_rr = 1; d_bv = 0; d_bpc = '0;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_head[k] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                m_mem[k][j] = 32'h0;
                m_bad[k][j] = 0;
            end
        end
        test_reset();
        test_load_fetch();
        test_fault();
        test_high_base();
        test_backpressure();
        test_reset_mid();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_mem_fetch.md
INSTR_MEM_FETCH -- requirements
Module: instr_mem_fetch

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 16, meaning words stored; power of 2, at least 2.
REQ-003 SHALL provide parameter BASE_ADDR, default 32'h0, meaning byte address of word 0; DEPTH*4-aligned.
REQ-004 SHALL provide parameter NOP_WORD, default all-zero DATA_W, meaning the word returned on any fault.
REQ-005 SHALL provide ports: clk  in  1  sole clock, rising edge.
REQ-006 SHALL provide: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL provide: load_mode  in  1  high selects program-load mode.
REQ-008 SHALL provide: load_valid  in  1  write strobe, load_addr  in  log2(DEPTH)  word index, load_data  in  DATA_W  word.
REQ-009 SHALL provide: req_valid  in  1, req_ready  out  1, req_pc  in  32  byte address of fetch.
REQ-010 SHALL provide: rsp_valid  out  1, rsp_ready  in  1, rsp_instr  out  DATA_W, rsp_fault  out  1.
REQ-011 SHALL provide: load_count  out  log2(DEPTH)+1  words written since entering LOAD; parity_err  out  1.

Function
REQ-012 SHALL implement states IDLE, LOAD, RUN; IDLE lasts exactly one cycle after reset release, then goes to LOAD if load_mode=1, else RUN.
REQ-013 SHALL move RUN->LOAD on load_mode=1 only when rsp_valid=0 or a response handshake completes that cycle, and LOAD->RUN on load_mode=0.
REQ-014 SHALL write load_data to word load_addr on each cycle with state=LOAD and load_valid=1; load_valid outside LOAD is ignored.
REQ-015 SHALL clear load_count on entry to LOAD and increment it per accepted write, saturating at DEPTH.
REQ-016 SHALL drive req_ready = (state==RUN) and (rsp_valid==0 or rsp_ready==1).
REQ-017 SHALL accept a fetch when req_valid and req_ready are high, and present its response with rsp_valid=1 on the next cycle (latency 1).
REQ-018 SHALL hold rsp_valid, rsp_instr, rsp_fault stable while rsp_valid=1 and rsp_ready=0.
REQ-019 SHALL clear rsp_valid after a response handshake unless a new fetch is accepted in the same cycle (back-to-back throughput 1/cycle).
REQ-020 SHALL return word ((req_pc-BASE_ADDR)>>2) with rsp_fault=0 when BASE_ADDR <= req_pc < BASE_ADDR+4*DEPTH and req_pc[1:0]=0.
REQ-021 SHALL return NOP_WORD with rsp_fault=1 when req_pc is out of range or misaligned; no wrap-around of the address is permitted.
REQ-022 SHALL compute the range check at full 32-bit width so that BASE_ADDR+4*DEPTH near 2^32 cannot overflow into an in-range result.
REQ-023 SHALL not forward a same-cycle load write to a fetch; fetches are impossible in LOAD by REQ-016.

Reset
REQ-024 SHALL on rst_n=0 immediately force state=IDLE, rsp_valid=0, rsp_instr=NOP_WORD, rsp_fault=0, req_ready=0, load_count=0, parity_err=0.
REQ-025 SHALL not reset memory contents; words written before a reset are retained.
REQ-026 SHALL discard any pending response when reset asserts mid-transfer; no response is produced after reset for a fetch accepted before it.

Configuration
REQ-027 SHALL, with macro IMEM_PARITY_EN defined, store an even-parity bit per word on load and check it on every in-range fetch.
REQ-028 SHALL, with IMEM_PARITY_EN defined and a parity mismatch, return NOP_WORD with rsp_fault=1 and set sticky parity_err until reset or entry to LOAD.
REQ-029 SHALL, without IMEM_PARITY_EN, store no parity bits and tie parity_err to 0.

Verification
REQ-030 SHALL cover: load_mode=1, write words 0..3 = 32'h00041800, 32'h00051800, 32'h00061800, 32'h00071800, load_mode=0, fetch pc 0,4,8,12 -> those words in order, rsp_fault=0, load_count=4.
REQ-031 SHALL cover: fetch pc=64 and pc=6 with DEPTH=16, BASE_ADDR=0 -> rsp_instr=NOP_WORD, rsp_fault=1 for both.
REQ-032 SHALL cover: req_valid held high, rsp_ready low for 3 cycles after first response -> rsp stable, req_ready=0, no fetch lost or duplicated once rsp_ready rises.
REQ-033 SHALL cover: rst_n pulled low while rsp_valid=1 -> rsp_valid=0 same cycle; after release fetch of pc=4 returns previously loaded 32'h00051800.
REQ-034 SHALL cover: BASE_ADDR=32'hFFFF_FFC0, DEPTH=16, fetch pc=32'h0000_0000 -> rsp_fault=1.
REQ-035 SHALL cover (IMEM_PARITY_EN): force a stored parity bit flip on word 2, fetch pc=8 -> NOP_WORD, rsp_fault=1, parity_err=1 until reset.
